// File: rtl/axis_uart_pkg.sv
// Types and defaults shared by the UART bridge and its AXI-Stream receive framer.
package axis_uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  typedef struct packed {
    logic                     last;
    logic [DATA_BITS_DEF-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented while not empty.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module axis_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  // Zero while empty so the output is defined straight out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axis_uart_rx_framer.sv
// Repacks received UART bytes into an AXI-Stream with tlast on idle timeout
// or maximum frame length; a small FIFO absorbs downstream backpressure.
module axis_uart_rx_framer
  import axis_uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int FIFO_DEPTH  = 16,
  parameter int IDLE_CYCLES = 1000,
  parameter int MAX_LEN     = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [DATA_BITS-1:0]         rx_data,
  output logic [DATA_BITS-1:0]         m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int IW = $clog2(IDLE_CYCLES);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;
  logic [LW-1:0]        len;
  logic [IW-1:0]        idle_cnt;

  logic                 len_full;
  logic                 timeout;
  logic                 push;
  logic                 push_last;
  logic [DATA_BITS:0]   fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_drop;

  // A new byte always beats a timeout firing in the same cycle.
  assign len_full  = (len == LW'(MAX_LEN));
  assign timeout   = hold_valid && !rx_valid && (idle_cnt == IW'(IDLE_CYCLES - 1));
  assign push      = (rx_valid && hold_valid) || timeout;
  assign push_last = timeout || len_full;

  // Hold stage: the newest byte waits here until its last flag is known.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      len        <= '0;
      idle_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= fifo_drop;
      if (rx_valid) begin
        hold_valid <= 1'b1;
        idle_cnt   <= '0;
        len        <= (!hold_valid || len_full) ? LW'(1) : len + LW'(1);
      end else if (timeout) begin
        hold_valid <= 1'b0;
        idle_cnt   <= '0;
        len        <= '0;
      end else if (hold_valid && (idle_cnt != IW'(IDLE_CYCLES - 1))) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_valid) hold_data <= rx_data;
  end

  // FIFO stage: entries are {last, data}, presented show-ahead.
  axis_sync_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({push_last, hold_data}),
    .pop       (m_axis_tready),
    .rd_data   (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[DATA_BITS-1:0];
  assign m_axis_tlast  = fifo_dout[DATA_BITS];

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_axis_uart_rx_framer.sv
// Directed, table-driven bench for axis_uart_rx_framer with a short idle
// timeout, a 4-byte frame limit and a 4-entry FIFO.
module tb_axis_uart_rx_framer;
  import axis_uart_pkg::*;

  localparam int IDLE = 20;

  typedef struct {
    logic [7:0] data;
    int         gap;
    logic       exp_last;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       overflow;
  logic [2:0] fifo_count;

  int          n_total = 0;
  int          n_pass  = 0;
  int          ovf_cnt = 0;
  fifo_entry_t got_q[$];
  vec_t        vec [9];

  always #5 clk = ~clk;

  axis_uart_rx_framer #(
    .DATA_BITS   (8),
    .FIFO_DEPTH  (4),
    .IDLE_CYCLES (IDLE),
    .MAX_LEN     (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .overflow      (overflow),
    .fifo_count    (fifo_count)
  );

  // Record every handshake and every overflow-high cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) got_q.push_back(fifo_entry_t'({tlast, tdata}));
    if (overflow) ovf_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_beat(input string name, input int base, input int idx,
                          input logic [7:0] d, input logic l);
    if (got_q.size() <= base + idx) begin
      n_total++;
      $display("FAIL %s[%0d]: beat missing, expected data 0x%0h last %0d", name, idx, d, l);
    end else begin
      chk($sformatf("%s[%0d].data", name, idx), 32'(got_q[base+idx].data), 32'(d));
      chk($sformatf("%s[%0d].last", name, idx), 32'(got_q[base+idx].last), 32'(l));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic run_seq(input string name, input int first, input int n);
    int base;
    base = got_q.size();
    for (int i = 0; i < n; i++) begin
      send(vec[first+i].data);
      if (i < n - 1) tick(vec[first+i].gap - 1);
    end
    tick(IDLE - 1);
    chk({name, " tvalid before timeout"}, 32'(tvalid), 32'd0);
    tick(1);
    chk({name, " tvalid at timeout"}, 32'(tvalid), 32'd1);
    chk({name, " tdata at timeout"}, 32'(tdata), 32'(vec[first+n-1].data));
    chk({name, " tlast at timeout"}, 32'(tlast), 32'd1);
    tick(4);
    chk({name, " beats"}, 32'(got_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      chk_beat(name, base, i, vec[first+i].data, vec[first+i].exp_last);
  endtask

  initial begin
    int base;
    int ob;

    vec[0] = '{8'h11, 5, 1'b0};
    vec[1] = '{8'h22, 5, 1'b0};
    vec[2] = '{8'h33, 5, 1'b1};
    vec[3] = '{8'hA0, 2, 1'b0};
    vec[4] = '{8'hA1, 2, 1'b0};
    vec[5] = '{8'hA2, 2, 1'b0};
    vec[6] = '{8'hA3, 2, 1'b1};
    vec[7] = '{8'hA4, 2, 1'b0};
    vec[8] = '{8'hA5, 2, 1'b1};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tready   = 1'b1;
    tick(2);
    chk("reset tvalid", 32'(tvalid), 32'd0);
    chk("reset tlast", 32'(tlast), 32'd0);
    chk("reset tdata", 32'(tdata), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset fifo_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Idle-timeout framing, then length-limited framing.
    run_seq("t1", 0, 3);
    run_seq("t2", 3, 6);

    // Backpressure: each byte times out alone; the fifth and sixth are dropped.
    tready = 1'b0;
    base = got_q.size();
    ob = ovf_cnt;
    for (int i = 0; i < 6; i++) begin
      send(8'hB0 + 8'(i));
      tick(24);
    end
    chk("t3 overflow pulses", 32'(ovf_cnt - ob), 32'd2);
    chk("t3 fifo_count full", 32'(fifo_count), 32'd4);
    chk("t3 tvalid held", 32'(tvalid), 32'd1);
    chk("t3 head tdata", 32'(tdata), 32'hB0);
    chk("t3 head tlast", 32'(tlast), 32'd1);
    tready = 1'b1;
    tick(6);
    chk("t3 tvalid drained", 32'(tvalid), 32'd0);
    chk("t3 fifo_count drained", 32'(fifo_count), 32'd0);
    chk("t3 beats", 32'(got_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) chk_beat("t3", base, i, 8'hB0 + 8'(i), 1'b1);

    // Second byte lands exactly on the would-be timeout cycle.
    base = got_q.size();
    send(8'hC0);
    tick(IDLE - 1);
    send(8'hC1);
    tick(25);
    chk("t4 beats", 32'(got_q.size() - base), 32'd2);
    chk_beat("t4", base, 0, 8'hC0, 1'b0);
    chk_beat("t4", base, 1, 8'hC1, 1'b1);

    // Full FIFO with a simultaneous pop and push.
    tready = 1'b0;
    base = got_q.size();
    ob = ovf_cnt;
    for (int i = 0; i < 5; i++) begin
      send(8'hD0 + 8'(i));
      tick(1);
    end
    chk("t5 fifo_count full", 32'(fifo_count), 32'd4);
    tready = 1'b1;
    send(8'hD5);
    chk("t5 fifo_count push+pop", 32'(fifo_count), 32'd4);
    chk("t5 head after pop", 32'(tdata), 32'hD1);
    tick(1);
    chk("t5 no overflow", 32'(ovf_cnt - ob), 32'd0);
    tick(25);
    chk("t5 beats", 32'(got_q.size() - base), 32'd6);
    chk_beat("t5", base, 0, 8'hD0, 1'b0);
    chk_beat("t5", base, 1, 8'hD1, 1'b0);
    chk_beat("t5", base, 2, 8'hD2, 1'b0);
    chk_beat("t5", base, 3, 8'hD3, 1'b1);
    chk_beat("t5", base, 4, 8'hD4, 1'b0);
    chk_beat("t5", base, 5, 8'hD5, 1'b1);

    // Asynchronous reset with queued entries and a held byte.
    tready = 1'b0;
    send(8'hE0);
    tick(1);
    send(8'hE1);
    tick(1);
    send(8'hE2);
    chk("t6 fifo_count queued", 32'(fifo_count), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 tvalid in reset", 32'(tvalid), 32'd0);
    chk("t6 fifo_count in reset", 32'(fifo_count), 32'd0);
    chk("t6 tdata in reset", 32'(tdata), 32'd0);
    tick(2);
    rst_n  = 1'b1;
    tready = 1'b1;
    base = got_q.size();
    tick(30);
    chk("t6 no residue beats", 32'(got_q.size() - base), 32'd0);
    chk("t6 tvalid after release", 32'(tvalid), 32'd0);
    send(8'hF0);
    tick(25);
    chk("t6 beats after new byte", 32'(got_q.size() - base), 32'd1);
    chk_beat("t6", base, 0, 8'hF0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_uart_rx_framer.md
# axis_uart_rx_framer

- Downstream stage of the AXI-Stream/UART bridge.
- Consumes the bridge's received-byte pulses (`rx_valid`/`rx_data`) and repacks them into an AXI-Stream master with backpressure.
- Frames are delimited by `tlast`, generated on line-idle timeout or at a maximum frame length.
- A small FIFO absorbs backpressure; bytes arriving with the FIFO full are dropped and flagged.

## Interface

Parameters:

- `DATA_BITS`, 8: byte width, matches the bridge.
- `FIFO_DEPTH`, 16: entries, power of two, ≥2.
- `IDLE_CYCLES`, 1000: idle clocks after a byte that close the frame, ≥2.
- `MAX_LEN`, 64: maximum bytes per frame, ≥2.

Ports:

- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle pulse, byte received.
- `rx_data` in DATA_BITS: byte, valid with `rx_valid`.
- `m_axis_tdata` out DATA_BITS: head-of-FIFO byte.
- `m_axis_tvalid` out 1: FIFO not empty.
- `m_axis_tready` in 1: consumer ready.
- `m_axis_tlast` out 1: head byte ends a frame.
- `overflow` out 1: one-cycle pulse, entry dropped.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation

Holding stage:

- Registers `hold_valid`, `hold_data`, `len`, `idle_cnt`; the newest byte always waits in hold, because its `last` flag is not yet known.
- `rx_valid` while `!hold_valid`: load hold, `len`=1, `idle_cnt`=0.
- `rx_valid` while `hold_valid`:
  - Push {hold_data, last=(len==MAX_LEN)}, then load the new byte.
  - `len` = (len==MAX_LEN) ? 1 : len+1; `idle_cnt`=0.
- `hold_valid`, no `rx_valid`: `idle_cnt`++.
- Timeout, when `idle_cnt`==IDLE_CYCLES-1 and no `rx_valid`: push {hold_data, last=1}, clear `hold_valid`, `len`=0.
- `rx_valid` and timeout in the same cycle: `rx_valid` wins; push follows the `len` rule and the timeout is cancelled.
- `idle_cnt` width is $clog2(IDLE_CYCLES); it saturates and never wraps while hold is valid.

FIFO:

- Show-ahead; entry is {last, data}.
- `m_axis_tvalid` = !empty; tdata/tlast are driven from the head entry.
- Pop on `tvalid && tready`.
- Push while full: accepted only if a pop occurs the same cycle. Otherwise the entry is dropped, `overflow` pulses, and `fifo_count` is unchanged. A dropped `last` is lost and not repaired.
- Pointers wrap modulo FIFO_DEPTH; the extra count bit distinguishes full from empty.
- AXIS rule: once `tvalid` is high, tdata/tlast stay stable until the pop.

Reset:

- Async low clears the FIFO, pointers, hold, `len` and `idle_cnt`.
- Outputs `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `overflow` and `fifo_count` all reset to 0.
- A partial frame in progress is discarded; no residue appears after release.

## Timing

- Byte captured at edge E.
- Next-byte push: the held byte is pushed at the edge that captures the following byte, and is visible on `tvalid` the cycle after that edge.
- Timeout push: at edge E+IDLE_CYCLES; `tvalid` is high from that edge, provided the FIFO was empty.
- Throughput: one push and one pop per cycle.
- `overflow` is asserted in the cycle after the failed push edge, for exactly one cycle.
- `fifo_count` updates on the push/pop edge: +1, −1, or 0 for a simultaneous push and pop.

## Structure

- Shared package `axis_uart_pkg`: `DATA_BITS` default and the FIFO entry typedef {last, data}. The bridge and the framer both use it.
- One sub-module, `axis_sync_fifo`: show-ahead, parameterised width/depth, with push/pop/full/empty/count. The framer instantiates it and holds the hold/idle/len logic itself.

## Test plan

Bench parameters: IDLE_CYCLES=20, MAX_LEN=4, FIFO_DEPTH=4.

1. Bytes 0x11, 0x22, 0x33, 5 cycles apart, `tready`=1 → stream 11/l0, 22/l0, 33/l1. 0x33 appears exactly 20 edges after its capture.
2. Six bytes 0xA0–0xA5, 2 cycles apart, `tready`=1 → tlast on A3 (length limit) and on A5 (timeout).
3. `tready`=0, six bytes 25 cycles apart:
   - Four entries are stored, all with last=1.
   - `overflow` pulses twice; `fifo_count`=4.
   - Raise `tready` → 4 bytes out, then `tvalid` drops to 0.
4. Second byte's `rx_valid` on the cycle timeout would fire (19 cycles after the first) → first byte exits with last=0; no spurious last.
5. FIFO full (count 4) with `tready`=1 and a push on the same cycle → no `overflow`, count stays 4, order preserved.
6. `rst_n` low with 2 entries queued and hold valid → `tvalid`/`fifo_count` go to 0 immediately; no output after release until new bytes arrive.
